// File: rtl/shift_seq_unit.sv
// shift_seq_unit: multi-cycle serial shifter (SLL / SRA), one bit per clock,
// Start/Busy/Done handshake, also drives the ALU output-mux select code.
module shift_seq_unit #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned SHAMT_W = 4
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic [WIDTH-1:0]   Hyrja,
    input  logic [SHAMT_W-1:0] Shamt,
    input  logic               Op,
    output logic [WIDTH-1:0]   Dalja,
    output logic [2:0]         S,
    output logic               Busy,
    output logic               Done
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [WIDTH-1:0]   work_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic               op_q;
    logic [WIDTH-1:0]   shifted;
    logic [WIDTH-1:0]   load_val;
    logic               load_op;
    logic               enter_done;

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the value/op captured on the edge that enters DONE
    always_comb begin
        state_nxt  = state;
        shifted    = op_q ? {work_q[WIDTH-1], work_q[WIDTH-1:1]}
                          : {work_q[WIDTH-2:0], 1'b0};
        load_val   = shifted;
        load_op    = op_q;
        enter_done = 1'b0;
        case (state)
            ST_IDLE: begin
                // A zero-length shift completes straight from the operand
                load_val = Hyrja;
                load_op  = Op;
                if (Start) begin
                    state_nxt = (Shamt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == SHAMT_W'(1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        enter_done = (state_nxt == ST_DONE) && (state != ST_DONE);
    end

    // Working register, counter and registered outputs
    always_ff @(posedge Clock) begin
        if (Reset) begin
            work_q <= '0;
            cnt_q  <= '0;
            op_q   <= 1'b0;
            Dalja  <= '0;
            S      <= 3'b000;
            Busy   <= 1'b0;
            Done   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        work_q <= Hyrja;
                        cnt_q  <= Shamt;
                        op_q   <= Op;
                    end
                end
                ST_SHIFT: begin
                    work_q <= shifted;
                    cnt_q  <= cnt_q - SHAMT_W'(1);
                end
                default: begin
                end
            endcase
            if (enter_done) begin
                Dalja <= load_val;
                S     <= {2'b11, load_op};
            end
            Busy <= (state_nxt != ST_IDLE);
            Done <= (state_nxt == ST_DONE);
        end
    end

endmodule

// File: tb/tb_shift_seq_unit.sv
// Self-checking bench for shift_seq_unit using an expected-result queue.
module tb_shift_seq_unit;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start;
    logic [15:0] Hyrja;
    logic [3:0]  Shamt;
    logic        Op;
    logic [15:0] Dalja;
    logic [2:0]  S;
    logic        Busy;
    logic        Done;

    typedef struct packed {
        logic [15:0] dalja;
        logic [2:0]  s;
    } exp_t;

    exp_t        sb_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] last_dalja  = 16'h0000;
    logic [2:0]  last_s      = 3'b000;

    shift_seq_unit #(.WIDTH(16), .SHAMT_W(4)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .Start (Start),
        .Hyrja (Hyrja),
        .Shamt (Shamt),
        .Op    (Op),
        .Dalja (Dalja),
        .S     (S),
        .Busy  (Busy),
        .Done  (Done)
    );

    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    function automatic exp_t model(input logic [15:0] h, input logic [3:0] n, input logic op);
        exp_t e;
        e.dalja = op ? 16'($signed(h) >>> n) : 16'(h << n);
        e.s     = {2'b11, op};
        return e;
    endfunction

    // Pop the expected entry and compare it against the outputs at a Done cycle
    task automatic check_result(input string name);
        exp_t e;
        vectors++;
        if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s: Done with empty scoreboard, Dalja=%h S=%b", name, Dalja, S);
        end else begin
            e = sb_q.pop_front();
            if (Dalja !== e.dalja || S !== e.s) begin
                miscompares++;
                $display("FAIL %s: got Dalja=%h S=%b, expected Dalja=%h S=%b",
                         name, Dalja, S, e.dalja, e.s);
            end
            last_dalja = e.dalja;
            last_s     = e.s;
        end
    endtask

    // One full operation; optional junk Start pulses while in flight
    task automatic run_op(input string name, input logic [15:0] h, input logic [3:0] n,
                          input logic op, input bit disturb);
        int cyc;
        int dones;
        Start = 1'b1; Hyrja = h; Shamt = n; Op = op;
        sb_q.push_back(model(h, n, op));
        step();
        Start = 1'b0;
        cyc   = 1;
        while (!Done && cyc < 40) begin
            vectors++;
            if (Busy !== 1'b1 || Dalja !== last_dalja || S !== last_s) begin
                miscompares++;
                $display("FAIL %s_busy: cycle %0d Busy=%b Dalja=%h S=%b, expected Busy=1 Dalja=%h S=%b",
                         name, cyc, Busy, Dalja, S, last_dalja, last_s);
            end
            if (disturb && cyc >= 2 && cyc <= 4) begin
                Start = 1'b1; Hyrja = 16'hDEAD; Shamt = 4'd1; Op = ~op;
            end else begin
                Start = 1'b0;
            end
            step();
            cyc++;
        end
        Start = 1'b0;
        vectors++;
        if (!Done || cyc != int'(n) + 1 || Busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_latency: Done=%b Busy=%b at cycle %0d, expected Done=1 Busy=1 at cycle %0d",
                     name, Done, Busy, cyc, int'(n) + 1);
        end
        if (Done) check_result(name);
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (Done === 1'b1) dones++;
        end
        vectors++;
        if (dones != 0 || Busy !== 1'b0 || Dalja !== last_dalja || S !== last_s) begin
            miscompares++;
            $display("FAIL %s_after: extra Done=%0d Busy=%b Dalja=%h S=%b, expected 0/0/%h/%b",
                     name, dones, Busy, Dalja, S, last_dalja, last_s);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; Start = 1'b1; Hyrja = 16'h1234; Shamt = 4'd0; Op = 1'b1;
        step();
        step();
        Reset = 1'b0; Start = 1'b0;
        step();
        vectors++;
        if (Dalja !== 16'h0000 || S !== 3'b000 || Busy !== 1'b0 || Done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: Dalja=%h S=%b Busy=%b Done=%b, expected all zero", Dalja, S, Busy, Done);
        end
    endtask

    task automatic test_sll_basic();
        run_op("sll_1_4", 16'h0001, 4'd4, 1'b0, 1'b0);
    endtask

    task automatic test_sra();
        run_op("sra_8000_15", 16'h8000, 4'd15, 1'b1, 1'b0);
        run_op("sra_7ff0_4", 16'h7FF0, 4'd4, 1'b1, 1'b0);
    endtask

    task automatic test_boundaries();
        run_op("sll_ffff_15", 16'hFFFF, 4'd15, 1'b0, 1'b0);
        run_op("sra_a5a5_0", 16'hA5A5, 4'd0, 1'b1, 1'b0);
        run_op("sll_a5a5_0", 16'hA5A5, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic test_ignore_start();
        run_op("ignore_start", 16'h1234, 4'd8, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        int dones;
        Start = 1'b1; Hyrja = 16'h0F0F; Shamt = 4'd10; Op = 1'b0;
        step();
        Start = 1'b0;
        step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        vectors++;
        if (Dalja !== 16'h0000 || S !== 3'b000 || Busy !== 1'b0 || Done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: Dalja=%h S=%b Busy=%b Done=%b, expected all zero", Dalja, S, Busy, Done);
        end
        last_dalja = 16'h0000;
        last_s     = 3'b000;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (Done === 1'b1 || Busy === 1'b1) dones++;
        end
        vectors++;
        if (dones != 0) begin
            miscompares++;
            $display("FAIL reset_mid_nodone: %0d Busy/Done cycles after abort, expected 0", dones);
        end
        run_op("post_reset", 16'h00F0, 4'd3, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        int dcount = 0;
        int d1 = -1;
        int d2 = -1;
        Start = 1'b1; Hyrja = 16'h0003; Shamt = 4'd1; Op = 1'b0;
        sb_q.push_back(model(16'h0003, 4'd1, 1'b0));
        sb_q.push_back(model(16'h0101, 4'd2, 1'b0));
        step();
        Hyrja = 16'h0101; Shamt = 4'd2;
        for (int c = 1; c < 20; c++) begin
            if (Done) begin
                check_result("b2b");
                dcount++;
                if (dcount == 1) d1 = c;
                if (dcount == 2) begin
                    d2 = c;
                    break;
                end
            end else if (dcount == 1) begin
                vectors++;
                if (Dalja !== 16'h0006 || S !== 3'b110) begin
                    miscompares++;
                    $display("FAIL b2b_hold: cycle %0d Dalja=%h S=%b, expected 0006/110", c, Dalja, S);
                end
                if (c == d1 + 1) begin
                    vectors++;
                    if (Busy !== 1'b0) begin
                        miscompares++;
                        $display("FAIL b2b_idle: Busy=%b after first Done, expected 0", Busy);
                    end
                end
                if (c == d1 + 2) Start = 1'b0;
            end
            step();
        end
        Start = 1'b0;
        vectors++;
        if (d1 != 2 || d2 != 6) begin
            miscompares++;
            $display("FAIL b2b_timing: Done cycles %0d,%0d, expected 2,6", d1, d2);
        end
        for (int i = 0; i < 4; i++) step();
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Hyrja = '0; Shamt = '0; Op = 1'b0;
        test_reset();
        test_sll_basic();
        test_sra();
        test_boundaries();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shift_seq_unit.md
Name: shift_seq_unit

Overview:
- Multi-cycle serial shifter for the 16-bit CPU. It produces the SLL and SRA results that the ALU-output operation select mux consumes.
- It shifts one bit per clock and uses a Start/Busy/Done handshake.
- Alongside the result it drives the 3-bit select code (110 = SLL, 111 = SRA) for that mux, so the controller does not need to re-derive it.

Parameters:
- WIDTH, 16, data width of operand and result.
- SHAMT_W, 4, width of the shift amount; maximum shift is 2^SHAMT_W - 1.

Ports:
- Clock  input  1  single system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request strobe; accepted only when Busy=0.
- Hyrja  input  WIDTH  operand to shift; sampled when Start is accepted.
- Shamt  input  SHAMT_W  shift amount N; sampled when Start is accepted.
- Op  input  1  operation: 0 = SLL (logical left), 1 = SRA (arithmetic right); sampled when Start is accepted.
- Dalja  output  WIDTH  final shift result.
- S  output  3  select code for the operation mux: 110 = SLL result, 111 = SRA result.
- Busy  output  1  high while an operation is in flight, including the Done cycle.
- Done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (synchronous, active-high, dominates all other inputs):
  - state returns to IDLE.
  - Dalja=0, S=000, Busy=0, Done=0.
  - Working register and counter are cleared.
  - Reset mid-operation aborts that operation with no Done pulse. Outputs read zero in the cycle after the Reset edge.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - Busy=0, Done=0.
  - On an edge with Start=1: latch Hyrja into the working register, Shamt into the counter, and Op.
  - If Shamt=0, go to DONE; otherwise go to SHIFT.
- SHIFT:
  - Each edge shifts the working register by exactly one bit and decrements the counter.
  - SLL: shift left, zero fill at bit 0.
  - SRA: shift right, bit WIDTH-1 replicated into the vacated MSB.
  - The edge on which the counter goes 1→0 moves the state to DONE.
- DONE:
  - Lasts exactly one cycle; Done=1, Busy=1.
  - Next edge returns to IDLE unconditionally.
- Outputs:
  - Dalja and S are registered. They load (working-register value, {1,1,Op}) on the edge that enters DONE.
  - They hold until the next operation enters DONE, or until Reset.
  - Intermediate shift values are never visible on Dalja.
- Busy = (state != IDLE).
- Start handling:
  - Start is ignored in SHIFT and DONE; Hyrja, Shamt and Op are not sampled there.
  - An ignored Start is not queued. The requester must hold or re-assert Start once Busy=0.
- Latency: with Start sampled on edge k and shift amount N, state is DONE after edge k+N.
  - Done is high in the (N+1)-th cycle after the Start cycle; N=0 means the immediately following cycle.
  - Busy is high for N+1 cycles.
- Throughput: the next Start can be accepted in the first cycle after Done, i.e. N+2 cycles per operation.
- Width rules:
  - Shifting by N equals a single combinational shift by N (SLL: Hyrja<<N; SRA: signed Hyrja>>>N).
  - Maximum N = 15 for the default parameters; there is no modulo wrap beyond the counter width.
- Simultaneous Start and Reset on the same edge: Reset wins and the Start is dropped.

Test Plan:
- Reset, then Start with Hyrja=0x0001, Shamt=4, Op=0 → Busy high for 5 cycles; Done pulses in the 5th cycle after Start; Dalja=0x0010, S=110.
- Start with Hyrja=0x8000, Shamt=15, Op=1 → Done 16 cycles after Start; Dalja=0xFFFF, S=111. Then Hyrja=0x7FF0, Shamt=4, Op=1 → Dalja=0x07FF.
- Start with Hyrja=0xFFFF, Shamt=15, Op=0 → Dalja=0x8000. Then Hyrja=0xA5A5, Shamt=0, Op=1 → Done in the next cycle, Dalja=0xA5A5, S=111.
- During a Shamt=8 operation, pulse Start with different Hyrja/Op → ignored; result matches the original request; Done pulses exactly once.
- Assert Reset on the 3rd cycle of a Shamt=10 operation → next cycle Dalja=0, S=000, Busy=0, Done=0; no Done pulse follows. A new Start then completes normally.
- Back-to-back: Start asserted continuously for two SLL ops (Shamt=1, then Shamt=2) → second op accepted in the cycle after the first Done. Results are correct, and Dalja/S hold between the two Done pulses.
